// File: rtl/pwm_mixer_nch_if.sv
// rtl/pwm_mixer_nch_if.sv - encoder/PWM/debug signal bundle for pwm_mixer_nch
interface pwm_mixer_nch_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       enc_a;
    logic [NUM_CH-1:0]       enc_b;
    logic [NUM_CH-1:0]       pwm_out;
    logic [NUM_CH*CNT_W-1:0] enc_val;
    logic [SEL_W-1:0]        dbg_sel;
    logic [CNT_W-1:0]        dbg_val;

    modport master (
        output enc_a, enc_b, dbg_sel,
        input  pwm_out, enc_val, dbg_val
    );

    modport slave (
        input  enc_a, enc_b, dbg_sel,
        output pwm_out, enc_val, dbg_val
    );
endinterface

// File: rtl/pwm_mixer_nch.sv
// rtl/pwm_mixer_nch.sv - NUM_CH quadrature encoders driving NUM_CH PWM outputs with debug readback
// Optional PWM_STAGGER_EN offsets each channel's PWM compare count to spread rising edges.
module pwm_mixer_nch #(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = 8,
    parameter int DB_DIV   = 4,
    parameter int SATURATE = 1,
    parameter int STEP     = 1
) (
    input  logic           clk,
    input  logic           reset,
    pwm_mixer_nch_if.slave bus
);
    localparam int               PW       = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DB_DIV - 1);
    localparam logic [CNT_W-1:0] MAX      = '1;
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W + 1)'(STEP);

    logic [NUM_CH-1:0] a_s1, a_s2, b_s1, b_s2;
    logic [NUM_CH-1:0] a_db, b_db, a_prv, b_prv;
    logic [NUM_CH-1:0] valid, inc, dcr;
    logic [PW-1:0]     presc;
    logic              tick;
    logic              dec_en;
    logic [CNT_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0]  level     [NUM_CH];
    logic [CNT_W-1:0]  level_nxt [NUM_CH];
    logic [CNT_W-1:0]  duty      [NUM_CH];
    logic [CNT_W-1:0]  cmp_cnt   [NUM_CH];
    logic [CNT_W:0]    sum       [NUM_CH];
    logic [CNT_W:0]    dif       [NUM_CH];
    logic [NUM_CH-1:0] pwm_q;
    logic [CNT_W-1:0]  dbg;

    assign tick = (presc == PRE_LAST);

    // A change with B steady is a detent; direction is A xor B after the change.
    assign valid = {NUM_CH{dec_en}} & (a_db ^ a_prv) & ~(b_db ^ b_prv);
    assign inc   = valid & (a_db ^ b_db);
    assign dcr   = valid & ~(a_db ^ b_db);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]       = {1'b0, level[i]} + STEP_X;
            dif[i]       = {1'b0, level[i]} - STEP_X;
            level_nxt[i] = level[i];
            if (inc[i]) begin
                level_nxt[i] = (SATURATE != 0 && sum[i][CNT_W]) ? MAX : sum[i][CNT_W-1:0];
            end else if (dcr[i]) begin
                level_nxt[i] = (SATURATE != 0 && dif[i][CNT_W]) ? '0 : dif[i][CNT_W-1:0];
            end
        end
    end

`ifdef PWM_STAGGER_EN
    localparam int SPAN = (1 << CNT_W) / NUM_CH;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        assign cmp_cnt[g] = pwm_cnt + CNT_W'(g * SPAN);
    end
`else
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        assign cmp_cnt[g] = pwm_cnt;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1    <= '0;
            a_s2    <= '0;
            b_s1    <= '0;
            b_s2    <= '0;
            a_db    <= '0;
            b_db    <= '0;
            a_prv   <= '0;
            b_prv   <= '0;
            presc   <= '0;
            dec_en  <= 1'b0;
            pwm_cnt <= '0;
            pwm_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                level[i] <= '0;
                duty[i]  <= '0;
            end
        end else begin
            a_s1    <= bus.enc_a;
            a_s2    <= a_s1;
            b_s1    <= bus.enc_b;
            b_s2    <= b_s1;
            presc   <= tick ? '0 : presc + PW'(1);
            dec_en  <= tick;
            if (tick) begin
                a_db  <= a_s2;
                b_db  <= b_s2;
                a_prv <= a_db;
                b_prv <= b_db;
            end
            pwm_cnt <= pwm_cnt + CNT_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                level[i] <= level_nxt[i];
                // Shadow load at the channel's own period end keeps every period glitch-free.
                if (cmp_cnt[i] == MAX) begin
                    duty[i] <= level_nxt[i];
                end
                pwm_q[i] <= (duty[i] > cmp_cnt[i]);
            end
        end
    end

    always_comb begin
        dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.dbg_sel) == i) begin
                dbg = level[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.enc_val[g*CNT_W +: CNT_W] = level[g];
    end

    assign bus.pwm_out = pwm_q;
    assign bus.dbg_val = dbg;
endmodule

// File: tb/tb_pwm_mixer_nch.sv
// tb/tb_pwm_mixer_nch.sv - directed self-checking bench for pwm_mixer_nch
module tb_pwm_mixer_nch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [2:0] ea0 = '0, eb0 = '0, ea3 = '0, eb3 = '0;
    logic [1:0] dsel = '0;

`ifdef PWM_STAGGER_EN
    localparam int OFF2 = 2 * (256 / 3);
`else
    localparam int OFF2 = 0;
`endif

    pwm_mixer_nch_if #(.NUM_CH(3), .CNT_W(8)) bi0 ();
    pwm_mixer_nch_if #(.NUM_CH(3), .CNT_W(8)) bi1 ();
    pwm_mixer_nch_if #(.NUM_CH(3), .CNT_W(8)) bi2 ();
    pwm_mixer_nch_if #(.NUM_CH(3), .CNT_W(8)) bi3 ();

    assign bi0.enc_a = ea0;
    assign bi0.enc_b = eb0;
    assign bi1.enc_a = ea0;
    assign bi1.enc_b = eb0;
    assign bi2.enc_a = ea0;
    assign bi2.enc_b = eb0;
    assign bi3.enc_a = ea3;
    assign bi3.enc_b = eb3;
    assign bi0.dbg_sel = dsel;
    assign bi1.dbg_sel = 2'd0;
    assign bi2.dbg_sel = 2'd0;
    assign bi3.dbg_sel = 2'd0;

    pwm_mixer_nch u0 (.clk(clk), .reset(reset), .bus(bi0));
    pwm_mixer_nch #(.SATURATE(0)) u1 (.clk(clk), .reset(reset), .bus(bi1));
    pwm_mixer_nch #(.STEP(16)) u2 (.clk(clk), .reset(reset), .bus(bi2));
    pwm_mixer_nch #(.DB_DIV(8), .SATURATE(0), .STEP(16)) u3 (.clk(clk), .reset(reset), .bus(bi3));

    // k mirrors the cycle count since reset release, giving prescaler and PWM phase.
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit grp, input bit isb, input int ch, input logic v);
        if (grp) begin
            if (isb) eb3[ch] = v; else ea3[ch] = v;
        end else begin
            if (isb) eb0[ch] = v; else ea0[ch] = v;
        end
        cyc(20);
    endtask

    task automatic detent(input bit grp, input int ch, input bit cw);
        logic a, b, want_b;
        a = grp ? ea3[ch] : ea0[ch];
        b = grp ? eb3[ch] : eb0[ch];
        want_b = cw ? a : ~a;
        if (b != want_b) drive(grp, 1'b1, ch, want_b);
        drive(grp, 1'b0, ch, ~a);
    endtask

    task automatic wait_phase(input int modv, input int off, input int target);
        int n = 0;
        while (((k + off) % modv) != target && n < 600) begin
            cyc(1);
            n++;
        end
        chk("phase_wait", 32'(n < 600), 32'd1);
    endtask

    initial begin
        int bad, c0, c2, cs, cw1, n, hi;
        logic p1, p5, p6, p0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_enc_val", bi0.enc_val, 0);
        chk("rst_pwm_out", bi0.pwm_out, 0);
        chk("rst_dbg_val", bi0.dbg_val, 0);
        chk("rst_enc_val_u3", bi3.enc_val, 0);

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bi0.enc_val !== 0 || bi0.pwm_out !== 0 || bi0.dbg_val !== 0 ||
                bi3.enc_val !== 0 || bi3.pwm_out !== 0) bad++;
        end
        chk("idle_1000", bad, 0);
        cyc(1);

        repeat (5) detent(1'b0, 0, 1'b1);
        chk("cw5_u0", bi0.enc_val[7:0], 5);
        chk("cw5_u1", bi1.enc_val[7:0], 5);
        chk("cw5_step16", bi2.enc_val[7:0], 80);
        dsel = 2'd0;
        #1 chk("dbg_sel0", bi0.dbg_val, 5);

        wait_phase(256, 0, 0);
        c0 = 0; c2 = 0; cs = 0; cw1 = 0;
        p0 = 1'bx; p1 = 1'bx; p5 = 1'bx; p6 = 1'bx;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c0  += int'(bi0.pwm_out[0]);
            c2  += int'(bi0.pwm_out[2]);
            cs  += int'(bi2.pwm_out[0]);
            cw1 += int'(bi1.pwm_out[0]);
            case (k % 256)
                0: p0 = bi0.pwm_out[0];
                1: p1 = bi0.pwm_out[0];
                5: p5 = bi0.pwm_out[0];
                6: p6 = bi0.pwm_out[0];
                default: ;
            endcase
        end
        chk("pwm_hi_cnt_duty5", c0, 5);
        chk("pwm_hi_cnt_duty0", c2, 0);
        chk("pwm_hi_cnt_duty80", cs, 80);
        chk("pwm_hi_cnt_wrapbuild", cw1, 5);
        chk("pwm_ph0_low", p0, 0);
        chk("pwm_ph1_high", p1, 1);
        chk("pwm_ph5_high", p5, 1);
        chk("pwm_ph6_low", p6, 0);
        cyc(1);

        repeat (3) detent(1'b0, 1, 1'b0);
        chk("ccw3_sat", bi0.enc_val[15:8], 0);
        chk("ccw3_wrap", bi1.enc_val[15:8], 253);
        chk("ccw3_step16_sat", bi2.enc_val[15:8], 0);
        repeat (16) detent(1'b0, 1, 1'b1);
        chk("cw16_sat", bi0.enc_val[15:8], 16);
        chk("cw16_wrap", bi1.enc_val[15:8], 13);
        chk("cw16_step16_sat", bi2.enc_val[15:8], 255);
        dsel = 2'd1;
        #1 chk("dbg_sel1", bi0.dbg_val, 16);

        ea3[0] = 1'b1;
        eb3[0] = 1'b1;
        cyc(20);
        ea3[0] = 1'b0;
        eb3[0] = 1'b0;
        cyc(20);
        chk("ab_same_sample", bi3.enc_val[7:0], 0);
        wait_phase(8, 0, 2);
        ea3[0] = 1'b1;
        cyc(2);
        ea3[0] = 1'b0;
        cyc(30);
        chk("glitch_between_ticks", bi3.enc_val[7:0], 0);
        detent(1'b1, 0, 1'b1);
        chk("db8_real_detent", bi3.enc_val[7:0], 16);
        repeat (8) detent(1'b1, 1, 1'b1);
        chk("step16_wrap_half", bi3.enc_val[15:8], 128);
        repeat (8) detent(1'b1, 1, 1'b1);
        chk("step16_wrap_full", bi3.enc_val[15:8], 0);

        wait_phase(256, OFF2, 20);
        detent(1'b0, 2, 1'b1);
        chk("ch2_level", bi0.enc_val[23:16], 1);
        hi = 0;
        n = 0;
        @(negedge clk);
        while (((k + OFF2) % 256) != 1 && n < 600) begin
            hi += int'(bi0.pwm_out[2]);
            n++;
            @(negedge clk);
        end
        chk("ch2_reached_wrap", 32'(n < 600), 1);
        chk("ch2_old_duty_kept", hi, 0);
        chk("ch2_new_duty_rise", bi0.pwm_out[2], 1);
        @(negedge clk);
        chk("ch2_new_duty_fall", bi0.pwm_out[2], 0);
        cyc(1);
        dsel = 2'd2;
        #1 chk("dbg_sel2", bi0.dbg_val, 1);
        dsel = 2'd3;
        #1 chk("dbg_sel_oob", bi0.dbg_val, 0);
        dsel = 2'd0;

        ea0[0] = ~ea0[0];
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("midrst_enc_u0", bi0.enc_val, 0);
        chk("midrst_enc_u2", bi2.enc_val, 0);
        chk("midrst_enc_u3", bi3.enc_val, 0);
        chk("midrst_pwm_u0", bi0.pwm_out, 0);
        chk("midrst_pwm_u2", bi2.pwm_out, 0);
        chk("midrst_dbg", bi0.dbg_val, 0);
        ea0 = '0; eb0 = '0; ea3 = '0; eb3 = '0;
        cyc(1);
        reset = 1'b0;
        cyc(40);
        chk("post_rst_enc_u0", bi0.enc_val, 0);
        chk("post_rst_enc_u3", bi3.enc_val, 0);
        chk("post_rst_pwm_u1", bi1.pwm_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
